hazard_control_unit: RTL
========================

// Module: hazard_control_unit
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. It drives the stall and flush controls of
//  the IF/ID, ID/EX and EX/MEM registers from four sources: load-use hazards, branch mispredicts,
//  instruction-memory latency and data-memory wait handshakes. It has one small FSM for multi-cycle
//  redirect bubbles and D-memory waits.
// PARAMETERS
//  REDIRECT_BUBBLES  1    cycles Flush_D is held after a mispredict (>=1; extra cycles cover fetch latency)
//  WAIT_TIMEOUT      255  D-mem wait cycles before Mem_Timeout is raised (must be >=1)
// PORTS
//  CLK           in   1  clock
//  RST           in   1  reset, synchronous, active-high
//  Rs1_D,Rs2_D   in   5  source regs of instruction in decode
//  Valid_D       in   1  decode holds a real instruction
//  Rd_E          in   5  dest reg of instruction in execute
//  Mem_Read_E    in   1  execute instruction is a load
//  Valid_E       in   1  execute holds a real instruction
//  Mispredict_E  in   1  branch/jump resolved against prediction in execute
//  IMem_Ready    in   1  instruction memory returns data this cycle
//  DMem_Req_M    in   1  memory stage has an outstanding access
//  DMem_Ready_M  in   1  data memory completes access this cycle
//  Stall_F/D/E/M out  1  hold PC / IF-ID / ID-EX / EX-MEM (Stall_D drives IF/ID Stall_En)
//  Flush_D,Flush_E out 1 bubble IF/ID / ID-EX (Flush_D drives IF/ID Flush_D)
//  Mem_Timeout   out  1  sticky: D-mem wait exceeded WAIT_TIMEOUT
// BEHAVIOUR
//  States: RUN, FLUSH, DMEM_WAIT. Stall/flush outputs are combinational from inputs and state.
//  RST cycle: state<=RUN, counters<=0, Mem_Timeout<=0. All stalls are 0 and Flush_D=Flush_E=1 while RST=1.
//  Priority, highest first; exactly one rule applies per cycle:
//   1 dmem_wait = DMem_Req_M & !DMem_Ready_M: Stall_F/D/E/M=1, flushes 0. Enter or stay in DMEM_WAIT.
//     Mispredict_E is frozen with E, so it is serviced after the wait ends.
//   2 Mispredict_E: Flush_D=Flush_E=1, stalls 0. Flush counter <= REDIRECT_BUBBLES-1.
//     Go to FLUSH if that value is >0, else RUN.
//   3 state==FLUSH, count>0: Flush_D=1 only. Decrement; at 1->0 go to RUN.
//   4 load_use = Mem_Read_E & Valid_E & Valid_D & Rd_E!=0 & (Rd_E==Rs1_D | Rd_E==Rs2_D):
//     Stall_F=Stall_D=1, Flush_E=1, for exactly one cycle (the load then moves to M).
//   5 !IMem_Ready: Stall_F=1, Flush_D=1 (bubble into decode).
//   6 otherwise all outputs 0.
//  DMEM_WAIT: wait counter increments each stalled cycle and saturates.
//   - Counter reaching WAIT_TIMEOUT sets Mem_Timeout. It stays set until RST; stall continues.
//   - On DMem_Ready_M: counter clears; return to FLUSH if the flush count is >0, else RUN.
//   - The flush count holds while in DMEM_WAIT.
//  A mispredict during FLUSH reloads the counter; it does not accumulate.
//  Load-use with Rd_E==x0, or with an invalid E or D, never stalls.
//  RST asserted mid-wait or mid-flush aborts immediately to RUN.
// CONFIGURATION
//  HAZARD_STATS_EN defined: adds outputs Stall_Cycles[31:0] and Flush_Cycles[31:0].
//   - Free-running wrap-around counts of cycles with Stall_F=1 and with Flush_D=1 (RST cycle excluded).
//   - Both zeroed by RST.
//  Undefined: these ports and their logic are absent.
// STRUCTURE
//  control_pkg: typedef enum logic[1:0] hazard_state_t {RUN,FLUSH,DMEM_WAIT}; localparam REG_X0=5'd0.
//  Sub-module load_use_detect: combinational comparator producing load_use, instanced once.
// TESTING
//  Rd_E=5,Mem_Read_E=1,Rs2_D=5, valid both -> one cycle Stall_F=Stall_D=Flush_E=1, then all 0.
//  Same as above but Rd_E=0 -> no stall, no flush.
//  Mispredict_E=1 one cycle, REDIRECT_BUBBLES=3 -> Flush_D high 3 consecutive cycles; Flush_E 1st only.
//  DMem_Req_M=1,Ready=0 for 4 cycles, Mispredict_E=1 throughout -> 4 cycles of all stalls, no flush,
//   then the flush fires on the cycle Ready=1.
//  WAIT_TIMEOUT=3, ready withheld 5 cycles -> Mem_Timeout rises at 3rd wait cycle, stays 1 until RST.
//  RST in FLUSH count=2 -> next cycle RUN, Flush_D=0 with idle inputs; HAZARD_STATS_EN counters=0.

Source files
------------

// File: rtl/control_pkg.sv
// Shared types and constants for the pipeline hazard control logic.
package control_pkg;

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    DMEM_WAIT
  } hazard_state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: a load in execute whose destination is read by decode.
module load_use_detect
  import control_pkg::*;
(
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  input  logic       valid_d,
  input  logic [4:0] rd_e,
  input  logic       mem_read_e,
  input  logic       valid_e,
  output logic       load_use
);

  // x0 is hard-wired to zero, so a "load into x0" can never create a dependency.
  assign load_use = mem_read_e & valid_e & valid_d & (rd_e != REG_X0) &
                    ((rd_e == rs1_d) | (rd_e == rs2_d));

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush sequencer for the 5-stage pipeline (load-use, mispredict, I-mem and D-mem waits).
// Define HAZARD_STATS_EN to add the Stall_Cycles / Flush_Cycles counters.
module hazard_control_unit
  import control_pkg::*;
#(
  parameter int REDIRECT_BUBBLES = 1,
  parameter int WAIT_TIMEOUT     = 255
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [4:0] Rs1_D,
  input  logic [4:0] Rs2_D,
  input  logic       Valid_D,
  input  logic [4:0] Rd_E,
  input  logic       Mem_Read_E,
  input  logic       Valid_E,
  input  logic       Mispredict_E,
  input  logic       IMem_Ready,
  input  logic       DMem_Req_M,
  input  logic       DMem_Ready_M,
  output logic       Stall_F,
  output logic       Stall_D,
  output logic       Stall_E,
  output logic       Stall_M,
  output logic       Flush_D,
  output logic       Flush_E,
  output logic       Mem_Timeout
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] Stall_Cycles,
  output logic [31:0] Flush_Cycles
`endif
);

  localparam int FCW = (REDIRECT_BUBBLES > 1) ? $clog2(REDIRECT_BUBBLES) : 1;
  localparam int WCW = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [FCW-1:0] FLUSH_RELOAD = FCW'(REDIRECT_BUBBLES - 1);
  localparam logic [WCW-1:0] WAIT_LIMIT   = WCW'(WAIT_TIMEOUT);

  hazard_state_t  state_reg, state_next;
  logic [FCW-1:0] flush_cnt_reg, flush_cnt_next;
  logic [WCW-1:0] wait_cnt_reg, wait_cnt_next;
  logic           timeout_reg, timeout_next;
  logic           load_use;
  logic           dmem_wait;

  load_use_detect u_load_use_detect (
    .rs1_d      (Rs1_D),
    .rs2_d      (Rs2_D),
    .valid_d    (Valid_D),
    .rd_e       (Rd_E),
    .mem_read_e (Mem_Read_E),
    .valid_e    (Valid_E),
    .load_use   (load_use)
  );

  assign dmem_wait   = DMem_Req_M & ~DMem_Ready_M;
  assign Mem_Timeout = timeout_reg;

  always_comb begin
    Stall_F        = 1'b0;
    Stall_D        = 1'b0;
    Stall_E        = 1'b0;
    Stall_M        = 1'b0;
    Flush_D        = 1'b0;
    Flush_E        = 1'b0;
    state_next     = state_reg;
    flush_cnt_next = flush_cnt_reg;
    wait_cnt_next  = '0;
    timeout_next   = timeout_reg;
    if (RST) begin
      Flush_D        = 1'b1;
      Flush_E        = 1'b1;
      state_next     = RUN;
      flush_cnt_next = '0;
      timeout_next   = 1'b0;
    end else if (dmem_wait) begin
      // Whole pipe freezes, including any mispredict sitting in E; flush count holds.
      Stall_F    = 1'b1;
      Stall_D    = 1'b1;
      Stall_E    = 1'b1;
      Stall_M    = 1'b1;
      state_next = DMEM_WAIT;
      if (wait_cnt_reg != WAIT_LIMIT) begin
        wait_cnt_next = wait_cnt_reg + WCW'(1);
      end else begin
        wait_cnt_next = wait_cnt_reg;
      end
      if (wait_cnt_next == WAIT_LIMIT) begin
        timeout_next = 1'b1;
      end
    end else if (Mispredict_E) begin
      Flush_D        = 1'b1;
      Flush_E        = 1'b1;
      flush_cnt_next = FLUSH_RELOAD;
      state_next     = (FLUSH_RELOAD != '0) ? FLUSH : RUN;
    end else if (state_reg == FLUSH && flush_cnt_reg != '0) begin
      Flush_D        = 1'b1;
      flush_cnt_next = flush_cnt_reg - FCW'(1);
      state_next     = (flush_cnt_reg == FCW'(1)) ? RUN : FLUSH;
    end else begin
      // Leaving DMEM_WAIT resumes any redirect bubbles still owed.
      state_next = (flush_cnt_reg != '0) ? FLUSH : RUN;
      if (load_use) begin
        Stall_F = 1'b1;
        Stall_D = 1'b1;
        Flush_E = 1'b1;
      end else if (!IMem_Ready) begin
        Stall_F = 1'b1;
        Flush_D = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= RUN;
      flush_cnt_reg <= '0;
      wait_cnt_reg  <= '0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      flush_cnt_reg <= flush_cnt_next;
      wait_cnt_reg  <= wait_cnt_next;
      timeout_reg   <= timeout_next;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles_reg;
  logic [31:0] flush_cycles_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cycles_reg <= '0;
      flush_cycles_reg <= '0;
    end else begin
      if (Stall_F) stall_cycles_reg <= stall_cycles_reg + 32'd1;
      if (Flush_D) flush_cycles_reg <= flush_cycles_reg + 32'd1;
    end
  end

  assign Stall_Cycles = stall_cycles_reg;
  assign Flush_Cycles = flush_cycles_reg;
`endif

endmodule
